// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: bundles the per-master Wishbone buses, the shared slave bus and the arbiter status into one interface.
// Ports (all members, named from the arbiter's point of view):
//   m_we_i/m_stb_i/m_adr_i/m_dat_i  per-master request, master k in slice k
//   m_ack_o/m_err_o/m_dat_o         per-master response, err pulses with ack on timeout
//   s_we_o/s_stb_o/s_adr_o/s_dat_o  shared slave request, s_ack_i/s_dat_i slave response
//   busy_o/grant_o                  arbiter status
// Modport slave is taken by the arbiter, which is the slave every master sees;
// modport master is the environment side that drives masters and the slave model.
interface wb_rr_arbiter_if #(
  parameter int MastersNb = 2,
  parameter int AddrSz = 4,
  parameter int DataSz = 8
);
  localparam int GrantSz = $clog2(MastersNb);
  logic [MastersNb-1:0] m_we_i;
  logic [MastersNb-1:0] m_stb_i;
  logic [AddrSz*MastersNb-1:0] m_adr_i;
  logic [DataSz*MastersNb-1:0] m_dat_i;
  logic [MastersNb-1:0] m_ack_o;
  logic [MastersNb-1:0] m_err_o;
  logic [DataSz*MastersNb-1:0] m_dat_o;
  logic s_we_o;
  logic s_stb_o;
  logic [AddrSz-1:0] s_adr_o;
  logic [DataSz-1:0] s_dat_o;
  logic s_ack_i;
  logic [DataSz-1:0] s_dat_i;
  logic busy_o;
  logic [GrantSz-1:0] grant_o;
  modport slave (
    input m_we_i, m_stb_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_we_o, s_stb_o, s_adr_o, s_dat_o, busy_o, grant_o
  );
  modport master (
    output m_we_i, m_stb_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input m_ack_o, m_err_o, m_dat_o, s_we_o, s_stb_o, s_adr_o, s_dat_o, busy_o, grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin sharing of one Wishbone B4 slave between MastersNb masters, with per-transaction timeout.
// Ports: clk_i rising-edge clock, rst_ni synchronous active-low reset,
//        bus (wb_rr_arbiter_if.slave) carrying all master, slave and status signals.
// Interface parameters MastersNb/AddrSz/DataSz must match the ones given here.
module wb_rr_arbiter #(
  parameter int MastersNb = 2,
  parameter int AddrSz = 4,
  parameter int DataSz = 8,
  parameter int TimeoutCycles = 15
) (
  input logic clk_i,
  input logic rst_ni,
  wb_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(MastersNb);
  localparam int TW = $clog2(TimeoutCycles + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [GW-1:0] ptr, grant, sel, nxt;
  logic [TW-1:0] timer;
  logic busy, stb_g, we_g, ack, tmo, done;
  logic [AddrSz-1:0] adr_g;
  logic [DataSz-1:0] dat_g;
  // Explicit wrap keeps indices in range when MastersNb is not a power of two.
  function automatic int wrap(input int v);
    return v >= MastersNb ? v - MastersNb : v;
  endfunction
  // Scan downward so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    sel = ptr;
    for (int i = MastersNb - 1; i >= 0; i--)
      sel = bus.m_stb_i[wrap(int'(ptr) + i)] ? GW'(wrap(int'(ptr) + i)) : sel;
  end
  always_comb begin
    stb_g = 1'b0;
    we_g = 1'b0;
    adr_g = '0;
    dat_g = '0;
    for (int k = 0; k < MastersNb; k++)
      if (grant == GW'(k)) begin
        stb_g = bus.m_stb_i[k];
        we_g = bus.m_we_i[k];
        adr_g = bus.m_adr_i[k*AddrSz +: AddrSz];
        dat_g = bus.m_dat_i[k*DataSz +: DataSz];
      end
  end
  // A dropped strobe is an abort: it suppresses both ack and timeout.
  assign busy = state == BUSY;
  assign ack = busy & stb_g & bus.s_ack_i;
  assign tmo = busy & stb_g & ~bus.s_ack_i & (timer == TW'(TimeoutCycles));
  assign done = ~stb_g | bus.s_ack_i | tmo;
  assign nxt = grant == GW'(MastersNb - 1) ? '0 : grant + 1'b1;
  assign bus.s_stb_o = busy & stb_g & ~tmo;
  assign bus.s_we_o = busy & we_g;
  assign bus.s_adr_o = busy ? adr_g : '0;
  assign bus.s_dat_o = busy ? dat_g : '0;
  assign bus.m_ack_o = (ack | tmo) ? MastersNb'(1) << grant : '0;
  assign bus.m_err_o = tmo ? MastersNb'(1) << grant : '0;
  assign bus.busy_o = busy;
  assign bus.grant_o = grant;
  always_comb begin
    bus.m_dat_o = '0;
    for (int k = 0; k < MastersNb; k++)
      if (ack && grant == GW'(k)) bus.m_dat_o[k*DataSz +: DataSz] = bus.s_dat_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      timer <= '0;
    end else if (state == IDLE) begin
      if (|bus.m_stb_i) begin
        state <= BUSY;
        grant <= sel;
        timer <= '0;
      end
    end else if (done) begin
      state <= IDLE;
      ptr <= nxt;
    end else begin
      timer <= timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed self-checking bench for wb_rr_arbiter with three masters and a 15-cycle timeout.
module tb_wb_rr_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int failures = 0;
  wb_rr_arbiter_if #(.MastersNb(3), .AddrSz(4), .DataSz(8)) bus ();
  wb_rr_arbiter #(.MastersNb(3), .AddrSz(4), .DataSz(8), .TimeoutCycles(15)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic cyc;
    @(posedge clk_i);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.m_we_i = '0;
    bus.m_stb_i = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    repeat (2) cyc;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_stb", bus.s_stb_o, 0);
    chk("rst_ack", bus.m_ack_o, 0);
    rst_ni = 1'b1;
    // single write from m0
    bus.m_stb_i = 3'b001;
    bus.m_we_i = 3'b001;
    bus.m_adr_i = 12'h002;
    bus.m_dat_i = 24'h0000A5;
    #1;
    chk("t1_idle_busy", bus.busy_o, 0);
    chk("t1_idle_stb", bus.s_stb_o, 0);
    chk("t1_idle_adr", bus.s_adr_o, 0);
    cyc;
    bus.s_ack_i = 1'b1;
    #1;
    chk("t1_busy", bus.busy_o, 1);
    chk("t1_s_stb", bus.s_stb_o, 1);
    chk("t1_s_we", bus.s_we_o, 1);
    chk("t1_s_adr", bus.s_adr_o, 2);
    chk("t1_s_dat", bus.s_dat_o, 8'hA5);
    chk("t1_m_ack", bus.m_ack_o, 3'b001);
    chk("t1_m_err", bus.m_err_o, 0);
    cyc;
    bus.m_stb_i = '0;
    bus.m_we_i = '0;
    bus.s_ack_i = 1'b0;
    #1;
    chk("t1_after_busy", bus.busy_o, 0);
    chk("t1_after_ack", bus.m_ack_o, 0);
    // pointer is 1: m1 wins over m0, then m0 (scan from 2 wraps to 0)
    bus.m_stb_i = 3'b011;
    cyc;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 8'h33;
    #1;
    chk("ptr1_grant", bus.grant_o, 1);
    chk("ptr1_ack", bus.m_ack_o, 3'b010);
    chk("ptr1_dat", bus.m_dat_o, 24'h003300);
    cyc;
    bus.m_stb_i = 3'b001;
    bus.s_ack_i = 1'b0;
    cyc;
    bus.s_ack_i = 1'b1;
    #1;
    chk("ptr2_grant", bus.grant_o, 0);
    chk("ptr2_dat", bus.m_dat_o, 24'h000033);
    cyc;
    bus.m_stb_i = '0;
    bus.s_ack_i = 1'b0;
    rst_ni = 1'b0;
    cyc;
    rst_ni = 1'b1;
    // simultaneous reads from m0 and m1 after reset
    bus.m_stb_i = 3'b011;
    cyc;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 8'h11;
    #1;
    chk("t2_grant0", bus.grant_o, 0);
    chk("t2_ack0", bus.m_ack_o, 3'b001);
    chk("t2_dat0", bus.m_dat_o, 24'h000011);
    cyc;
    bus.m_stb_i = 3'b010;
    bus.s_ack_i = 1'b0;
    #1;
    chk("t2_gap_busy", bus.busy_o, 0);
    chk("t2_gap_ack", bus.m_ack_o, 0);
    cyc;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 8'h22;
    #1;
    chk("t2_grant1", bus.grant_o, 1);
    chk("t2_ack1", bus.m_ack_o, 3'b010);
    chk("t2_dat1", bus.m_dat_o, 24'h002200);
    cyc;
    bus.m_stb_i = '0;
    bus.s_ack_i = 1'b0;
    rst_ni = 1'b0;
    cyc;
    rst_ni = 1'b1;
    // continuous requests from all three masters with a zero-wait slave
    bus.m_stb_i = 3'b111;
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc;
      #1;
      chk("t3_busy", bus.busy_o, 1);
      chk("t3_grant", bus.grant_o, i % 3);
      chk("t3_ack", bus.m_ack_o, 3'b001 << (i % 3));
      cyc;
      #1;
      chk("t3_gap", bus.busy_o, 0);
    end
    // silent slave: m2 times out 15 cycles after BUSY entry
    bus.m_stb_i = 3'b100;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 8'hEE;
    for (int c = 0; c < 15; c++) begin
      cyc;
      #1;
      chk("t4_wait_ack", bus.m_ack_o, 0);
      chk("t4_wait_stb", bus.s_stb_o, 1);
    end
    cyc;
    #1;
    chk("t4_to_ack", bus.m_ack_o, 3'b100);
    chk("t4_to_err", bus.m_err_o, 3'b100);
    chk("t4_to_dat", bus.m_dat_o, 0);
    chk("t4_to_stb", bus.s_stb_o, 0);
    cyc;
    bus.m_stb_i = '0;
    #1;
    chk("t4_idle", bus.busy_o, 0);
    // ack in the very cycle the timer reaches 15: ack wins
    bus.m_stb_i = 3'b001;
    for (int c = 0; c < 15; c++) cyc;
    cyc;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 8'h5A;
    #1;
    chk("t5_ack", bus.m_ack_o, 3'b001);
    chk("t5_err", bus.m_err_o, 0);
    chk("t5_dat", bus.m_dat_o, 24'h00005A);
    cyc;
    bus.m_stb_i = '0;
    bus.s_ack_i = 1'b0;
    // reset during BUSY aborts without ack and clears the pointer
    bus.m_stb_i = 3'b010;
    cyc;
    #1;
    chk("t6_busy", bus.busy_o, 1);
    chk("t6_grant", bus.grant_o, 1);
    rst_ni = 1'b0;
    cyc;
    #1;
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_stb", bus.s_stb_o, 0);
    chk("t6_rst_ack", bus.m_ack_o, 0);
    rst_ni = 1'b1;
    bus.m_stb_i = 3'b011;
    cyc;
    #1;
    chk("t6_ptr0", bus.grant_o, 0);
    // master abort: stb drops mid-BUSY
    bus.m_stb_i = '0;
    bus.s_ack_i = 1'b1;
    #1;
    chk("t7_abort_stb", bus.s_stb_o, 0);
    chk("t7_abort_ack", bus.m_ack_o, 0);
    cyc;
    bus.s_ack_i = 1'b0;
    #1;
    chk("t7_idle", bus.busy_o, 0);
    bus.m_stb_i = 3'b011;
    cyc;
    #1;
    chk("t7_ptr_adv", bus.grant_o, 1);
    bus.m_stb_i = '0;
    cyc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
